accum_kernel_seq: RTL

Sequencer that owns one run of the HLS accumulate kernel (`main`) and its array memory port.
- Loads DEPTH words into the kernel's array from a valid/ready input stream.
- Launches the kernel and waits for completion.
- Counts run cycles, then drains the array through a backpressured output stream.
- Replaces bench-driven loading/readback so the kernel can sit in a larger system.

---
 rtl/accum_kernel_seq.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/accum_kernel_seq.sv
// Sequencer for one accumulate-kernel run: stream-load DEPTH words, launch, time the run, stream-drain the result.
// Load writes are combinational from the handshake; drain holds at most OBUF words (buffered + in flight), so out_ready backpressure never drops data.
module accum_kernel_seq #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1000,
    parameter int RD_LAT = 2,
    parameter int OBUF   = RD_LAT + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [63:0]       cycle_count,
    output logic              controlArr,
    output logic              r_enable,
    input  logic              w_enable,
    output logic              controlArrWEnable_a,
    output logic [ADDR_W-1:0] controlArrAddr_a,
    output logic [DATA_W-1:0] controlArrWData_a,
    input  logic [DATA_W-1:0] controlArrRData_a
);

    localparam int CW = ADDR_W + 1;
    localparam int PW = (OBUF > 1) ? $clog2(OBUF) : 1;
    localparam int OW = $clog2(OBUF + RD_LAT + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LAUNCH,
        S_RUN,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t            state;
    logic [CW-1:0]     lc;
    logic [CW-1:0]     rc;
    logic [CW-1:0]     oc;
    logic [RD_LAT-1:0] rd_sr;
    logic [DATA_W-1:0] buf_mem [OBUF];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [OW-1:0]     buf_cnt;
    logic [OW-1:0]     inflight;
    logic              load_hs;
    logic              pop;
    logic              push;
    logic              issue;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + OW'(rd_sr[i]);
        end
    end

    assign load_hs   = in_ready && in_valid;
    assign out_valid = (buf_cnt != '0);
    assign out_data  = out_valid ? buf_mem[rd_ptr] : '0;
    assign pop       = out_valid && out_ready;
    assign push      = rd_sr[RD_LAT-1];

    // A same-cycle pop frees its slot, which keeps the drain at one word per cycle.
    assign issue = (state == S_DRAIN) && (rc < CW'(DEPTH)) &&
                   ((buf_cnt - OW'(pop) + inflight + OW'(1)) <= OW'(OBUF));

    always_comb begin
        controlArrWEnable_a = load_hs;
        controlArrWData_a   = load_hs ? in_data : '0;
        controlArrAddr_a    = '0;
        if (state == S_LOAD) begin
            controlArrAddr_a = lc[ADDR_W-1:0];
        end else if (state == S_DRAIN) begin
            controlArrAddr_a = rc[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[wr_ptr] <= controlArrRData_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            controlArr  <= 1'b1;
            r_enable    <= 1'b0;
            in_ready    <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            cycle_count <= '0;
            lc          <= '0;
            rc          <= '0;
            oc          <= '0;
            rd_sr       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            buf_cnt     <= '0;
        end else begin
            done     <= 1'b0;
            r_enable <= 1'b0;

            rd_sr   <= (rd_sr << 1) | RD_LAT'(issue);
            buf_cnt <= buf_cnt + OW'(push) - OW'(pop);
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(OBUF - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(OBUF - 1)) ? '0 : rd_ptr + PW'(1);
                oc     <= oc + CW'(1);
            end
            if (issue) begin
                rc <= rc + CW'(1);
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LOAD;
                        lc       <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (load_hs) begin
                        lc <= lc + CW'(1);
                        if (lc == CW'(DEPTH - 1)) begin
                            state      <= S_LAUNCH;
                            in_ready   <= 1'b0;
                            controlArr <= 1'b0;
                            r_enable   <= 1'b1;
                        end
                    end
                end
                S_LAUNCH: begin
                    cycle_count <= '0;
                    state       <= S_RUN;
                end
                S_RUN: begin
                    if (w_enable) begin
                        state      <= S_DRAIN;
                        controlArr <= 1'b1;
                        rc         <= '0;
                        oc         <= '0;
                    end else if (cycle_count != '1) begin
                        cycle_count <= cycle_count + 64'd1;
                    end
                end
                S_DRAIN: begin
                    if (pop && (oc == CW'(DEPTH - 1))) begin
                        state <= S_FIN;
                        done  <= 1'b1;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
